// File: rtl/serial_arith_unit.sv
// Bit-serial WIDTH-bit add/subtract unit: operands arrive MSB first under en_i,
// and the (WIDTH+1)-bit result leaves MSB first under en_o.
module serial_arith_unit #(
    parameter int WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic op,
    input  logic ina,
    input  logic inb,
    output logic en_o,
    output logic out,
    output logic busy,
    output logic err
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_LAST_IN  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SEND_END = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CALC = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               op_q, op_d;
    logic [WIDTH:0]     res_q, res_d;
    logic               en_o_q, en_o_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_inc;

    // Subtraction wraps modulo 2^(WIDTH+1), so the MSB carries the borrow/sign.
    function automatic logic [WIDTH:0] calc_result(
        input logic             sub,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] ax;
        logic [WIDTH:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        calc_result = sub ? (ax - bx) : (ax + bx);
    endfunction

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        en_o_d  = 1'b0;
        out_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    a_d     = WIDTH'(ina);
                    b_d     = WIDTH'(inb);
                    op_d    = op;
                    cnt_d   = CNT_ONE;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (en_i) begin
                    a_d   = {a_q[WIDTH-2:0], ina};
                    b_d   = {b_q[WIDTH-2:0], inb};
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST_IN) begin
                        state_d = CALC;
                    end
                end else begin
                    // Truncated frame: drop the partial operands and flag it.
                    a_d     = '0;
                    b_d     = '0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            CALC: begin
                res_d   = calc_result(op_q, a_q, b_q);
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (cnt_q == CNT_SEND_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    en_o_d = 1'b1;
                    out_d  = res_q[WIDTH];
                    res_d  = {res_q[WIDTH-1:0], 1'b0};
                    cnt_d  = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            res_q   <= '0;
            en_o_q  <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            en_o_q  <= en_o_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign en_o = en_o_q;
    assign out  = out_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed bench for serial_arith_unit at WIDTH = 2, 4 and 8; one stimulus
// bus is steered to the instance selected by sel.
module tb_serial_arith_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'd0;
    logic       en_t = 1'b0;
    logic       op_t = 1'b0;
    logic       ina_t = 1'b0;
    logic       inb_t = 1'b0;

    logic en_i2, en_i4, en_i8;
    logic en_o2, out2, busy2, err2;
    logic en_o4, out4, busy4, err4;
    logic en_o8, out8, busy8, err8;
    logic obs_en_o, obs_out, obs_busy, obs_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign en_i2 = en_t & (sel == 2'd0);
    assign en_i4 = en_t & (sel == 2'd1);
    assign en_i8 = en_t & (sel == 2'd2);

    always_comb begin
        obs_en_o = en_o2;
        obs_out  = out2;
        obs_busy = busy2;
        obs_err  = err2;
        case (sel)
            2'd1: begin obs_en_o = en_o4; obs_out = out4; obs_busy = busy4; obs_err = err4; end
            2'd2: begin obs_en_o = en_o8; obs_out = out8; obs_busy = busy8; obs_err = err8; end
            default: ;
        endcase
    end

    serial_arith_unit #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en_i(en_i2), .op(op_t), .ina(ina_t), .inb(inb_t),
        .en_o(en_o2), .out(out2), .busy(busy2), .err(err2)
    );
    serial_arith_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en_i(en_i4), .op(op_t), .ina(ina_t), .inb(inb_t),
        .en_o(en_o4), .out(out4), .busy(busy4), .err(err4)
    );
    serial_arith_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en_i(en_i8), .op(op_t), .ina(ina_t), .inb(inb_t),
        .en_o(en_o8), .out(out8), .busy(busy8), .err(err8)
    );

    task automatic chk(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drive w operand bits MSB first; en_t is left high after the last bit.
    task automatic drive_bits(input int w, input logic o, input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            en_t  = 1'b1;
            op_t  = o;
            ina_t = a[w-1-i];
            inb_t = b[w-1-i];
        end
    endtask

    // Check the result frame that follows drive_bits; hold keeps en_t high
    // through CALC/SEND and releases it on the cycle SEND ends.
    task automatic expect_result(input int w, input logic [8:0] r, input string tag, input bit hold);
        @(negedge clk);
        if (!hold) begin
            en_t = 1'b0; ina_t = 1'b0; inb_t = 1'b0;
        end else begin
            ina_t = 1'b1; inb_t = 1'b1;
        end
        chk({tag, " lat1 en_o"}, obs_en_o, 1'b0);
        chk({tag, " lat1 busy"}, obs_busy, 1'b1);
        @(negedge clk);
        chk({tag, " lat2 en_o"}, obs_en_o, 1'b0);
        chk({tag, " lat2 busy"}, obs_busy, 1'b1);
        for (int j = 0; j <= w; j++) begin
            @(negedge clk);
            chk($sformatf("%s bit%0d en_o", tag, j), obs_en_o, 1'b1);
            chk($sformatf("%s bit%0d out", tag, j), obs_out, r[w-j]);
            chk($sformatf("%s bit%0d busy", tag, j), obs_busy, 1'b1);
            chk($sformatf("%s bit%0d err", tag, j), obs_err, 1'b0);
        end
        @(negedge clk);
        en_t = 1'b0; ina_t = 1'b0; inb_t = 1'b0;
        chk({tag, " end en_o"}, obs_en_o, 1'b0);
        chk({tag, " end out"}, obs_out, 1'b0);
        chk({tag, " end busy"}, obs_busy, 1'b0);
        chk({tag, " end err"}, obs_err, 1'b0);
        @(negedge clk);
        chk({tag, " idle busy"}, obs_busy, 1'b0);
        chk({tag, " idle en_o"}, obs_en_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state of every instance
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s[1:0];
            #1;
            chk($sformatf("rst sel%0d en_o", s), obs_en_o, 1'b0);
            chk($sformatf("rst sel%0d out", s), obs_out, 1'b0);
            chk($sformatf("rst sel%0d busy", s), obs_busy, 1'b0);
            chk($sformatf("rst sel%0d err", s), obs_err, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=2: 3+3=6, then 1-2=-1 (3'b111)
        sel = 2'd0;
        drive_bits(2, 1'b0, 8'h03, 8'h03);
        expect_result(2, 9'h006, "w2 add", 1'b0);
        drive_bits(2, 1'b1, 8'h01, 8'h02);
        expect_result(2, 9'h007, "w2 sub", 1'b0);

        // WIDTH=8: carry out, negative and positive differences
        sel = 2'd2;
        drive_bits(8, 1'b0, 8'hFF, 8'h01);
        expect_result(8, 9'h100, "w8 add ff01", 1'b0);
        drive_bits(8, 1'b1, 8'h05, 8'h07);
        expect_result(8, 9'h1FE, "w8 sub 0507", 1'b0);
        drive_bits(8, 1'b1, 8'h07, 8'h05);
        expect_result(8, 9'h002, "w8 sub 0705", 1'b0);

        // Truncated frame: 3 bits only, then a full 1+1 frame
        drive_bits(3, 1'b0, 8'hE0, 8'hE0);
        @(negedge clk);
        en_t = 1'b0;
        chk("trunc pre err", obs_err, 1'b0);
        @(negedge clk);
        chk("trunc err pulse", obs_err, 1'b1);
        chk("trunc busy", obs_busy, 1'b0);
        chk("trunc en_o", obs_en_o, 1'b0);
        @(negedge clk);
        chk("trunc err clear", obs_err, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("trunc quiet%0d en_o", i), obs_en_o, 1'b0);
        end
        drive_bits(8, 1'b0, 8'h01, 8'h01);
        expect_result(8, 9'h002, "w8 after trunc", 1'b0);

        // Async reset on the 4th output bit of A5+3C = 0_1110_0001
        drive_bits(8, 1'b0, 8'hA5, 8'h3C);
        @(negedge clk);
        en_t = 1'b0; ina_t = 1'b0; inb_t = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst mid bit3 en_o", obs_en_o, 1'b1);
        chk("rst mid bit3 out", obs_out, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rst mid en_o", obs_en_o, 1'b0);
        chk("rst mid out", obs_out, 1'b0);
        chk("rst mid busy", obs_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("post rst%0d en_o", i), obs_en_o, 1'b0);
            chk($sformatf("post rst%0d busy", i), obs_busy, 1'b0);
        end
        drive_bits(8, 1'b1, 8'h00, 8'h01);
        expect_result(8, 9'h1FF, "w8 sub after rst", 1'b0);

        // WIDTH=4: en_i held through CALC/SEND, 1010+0110 = 1_0000
        sel = 2'd1;
        drive_bits(4, 1'b0, 8'h0A, 8'h06);
        expect_result(4, 9'h010, "w4 hold", 1'b1);
        drive_bits(4, 1'b1, 8'h03, 8'h09);
        expect_result(4, 9'h01A, "w4 sub", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_arith_unit.md
Name: serial_arith_unit

Overview:
- Parametrised successor to the 2-bit serial adder.
- Receives two WIDTH-bit operands bit-serially, MSB first, framed by en_i.
- Computes an unsigned add or a two's-complement subtract, selected per frame.
- Returns the (WIDTH+1)-bit result bit-serially, MSB first, framed by en_o.
- Adds busy/err status and truncated-frame recovery; sits directly behind the serial stimulus driver, in place of the fixed-width adder.

Parameters:
WIDTH, 2, operand width in bits (>=2); result width is WIDTH+1.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en_i  input  1  input frame valid; high for exactly WIDTH consecutive cycles per frame
op  input  1  operation, sampled on the first en_i cycle of a frame: 0 = add, 1 = subtract (a - b)
ina  input  1  operand A serial bit, MSB first, valid while en_i high
inb  input  1  operand B serial bit, MSB first, valid while en_i high
en_o  output  1  output frame valid; high for exactly WIDTH+1 consecutive cycles
out  output  1  result serial bit, MSB first, valid while en_o high, 0 otherwise
busy  output  1  high whenever state != IDLE
err  output  1  one-cycle pulse on truncated input frame

Behaviour:
- Reset (async, rst=1): state=IDLE; en_o=0, out=0, busy=0, err=0; shift registers, bit counter and op latch cleared. Takes effect immediately in any state, including mid-RECV and mid-SEND; no partial output follows.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, RECV, CALC, SEND.
- IDLE:
  - en_i=1 at a posedge (call it edge k): capture ina/inb into A/B shift registers, latch op, count=1, go to RECV.
  - en_i=0: stay.
  - WIDTH=... a frame always contains at least one bit, so RECV is entered first even when WIDTH bits would fit.
- RECV:
  - en_i=1: shift in the next bit (A={A[WIDTH-2:0],ina}, same for B) and increment count.
  - When count reaches WIDTH, go to CALC on the same edge (edge k+WIDTH-1).
  - en_i=0 before WIDTH bits are collected: abort. Go to IDLE, pulse err=1 for one cycle, discard operands, emit no output.
- CALC (edge k+WIDTH):
  - add: R = {1'b0,A} + {1'b0,B}.
  - sub: R = ({1'b0,A} - {1'b0,B}) mod 2^(WIDTH+1); R[WIDTH] is the borrow/sign bit.
  - Load R into the output shift register; go to SEND.
- SEND (edges k+WIDTH+1 .. k+2*WIDTH+1):
  - en_o=1 with out=R[WIDTH] first, shifting left one bit per cycle for WIDTH+1 cycles.
  - After the last bit: en_o=0, out=0, go to IDLE.
- Latency: the first result bit appears at the edge two cycles after the last operand bit is sampled.
- Input gating:
  - en_i in CALC/SEND is ignored; no capture, no err.
  - Extra en_i cycles beyond WIDTH are ignored until IDLE. An en_i still high on the edge where SEND ends is not captured. A new frame is accepted only on an edge where state==IDLE before the edge.
  - Back-to-back frames: minimum gap from the last en_o cycle to the next en_i capture is one cycle.
- busy: 1 from the edge entering RECV through the last SEND cycle.
- err: never asserted together with en_o.

Test Plan:
- WIDTH=2, add, A=2'b11, B=2'b11 (en_i 2 cycles) -> en_o high 3 cycles starting 2 cycles after the last input bit; out=1,1,0 (6).
- WIDTH=8, add, A=8'hFF, B=8'h01 -> 9 serial bits 1_0000_0000; busy high 1+8+1+... until the 9th bit, then 0.
- WIDTH=8, sub, A=8'h05, B=8'h07 -> out serial 1_1111_1110 (-2); sub A=8'h07, B=8'h05 -> 0_0000_0010.
- WIDTH=8, en_i high only 3 cycles -> err pulses 1 cycle on the edge after en_i drops; en_o stays 0; a following full frame A=1, B=1 add -> 0_0000_0010.
- WIDTH=8, rst asserted asynchronously mid-SEND (4th output bit) -> en_o, out, busy drop to 0 before the next edge; no bits emitted after rst release until a new frame.
- WIDTH=4, en_i held high through CALC/SEND -> the result for the first 4 bits only; no capture until IDLE; err never asserted.
